// File: rtl/picorv32_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_bus_decoder
// Description : Address decoder and ready generator between the PicoRV32
//               native memory port and SLAVES memory-mapped slaves. The top
//               address bits select one slave, which gets a one-hot request.
//               Fixed-latency and ack-handshake slaves both complete with a
//               single cpu_ready pulse and registered read data. Unmapped
//               accesses complete with ERROR_DATA and set a sticky error flag.
//               Optional macro BUS_TIMEOUT_EN adds a BUSY watchdog that turns
//               a hung ack slave into an error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_bus_decoder #(
    parameter int                 SLAVES         = 8,
    parameter int                 SEL_START_BIT  = 28,
    parameter int                 SEL_BITS       = 4,
    parameter logic [SLAVES-1:0]  FIXED_MASK     = SLAVES'(8'b0000_0111),
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter logic [31:0]        ERROR_DATA     = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_valid,
    input  logic [31:0]           cpu_la_addr,
    input  logic [3:0]            cpu_wstrb,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic [SLAVES-1:0]     slave_req,
    input  logic [SLAVES-1:0]     slave_ack,
    input  logic [SLAVES*32-1:0]  slave_rdata,
    input  logic                  bus_error_clr,
    output logic                  bus_error,
    output logic [31:0]           error_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [SEL_BITS:0]   C_NUM_SLAVES = (SEL_BITS+1)'(SLAVES);
    localparam logic [SEL_BITS-1:0] C_SEL_ONE    = SEL_BITS'(1);

    state_t                 state_q;
    logic [SEL_BITS-1:0]    idx_q;
    logic [31:0]            addr_q;
    logic                   first_q;
    logic                   cpu_ready_q;
    logic [31:0]            cpu_rdata_q;
    logic                   bus_error_q;
    logic [31:0]            error_addr_q;

`ifdef BUS_TIMEOUT_EN
    localparam int          TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]        cnt_q;
`endif

    logic [SEL_BITS-1:0]    w_sel;
    logic                   w_mapped;
    logic [31:0]            w_rdata_sel;
    logic                   w_ack_sel;
    logic                   w_fixed_sel;

    // Write strobes are not forwarded: slaves see only the request line.
    logic                   w_unused_wstrb;
    assign w_unused_wstrb = ^cpu_wstrb;

    assign w_sel    = cpu_la_addr[SEL_START_BIT+SEL_BITS-1:SEL_START_BIT];
    assign w_mapped = (w_sel != '0) && ({1'b0, w_sel} <= C_NUM_SLAVES);

    // Select read data, ack and latency class of the latched slave index
    always_comb begin
        w_rdata_sel = '0;
        w_ack_sel   = 1'b0;
        w_fixed_sel = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (idx_q == SEL_BITS'(i)) begin
                w_rdata_sel = slave_rdata[32*i +: 32];
                w_ack_sel   = slave_ack[i];
                w_fixed_sel = FIXED_MASK[i];
            end
        end
    end

    // One-hot request while BUSY, decoded from the latched index
    always_comb begin
        slave_req = '0;
        if (state_q == ST_BUSY) begin
            for (int i = 0; i < SLAVES; i++) begin
                slave_req[i] = (idx_q == SEL_BITS'(i));
            end
        end
    end

    // Transaction FSM with registered ready, read data and error reporting
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            first_q      <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            bus_error_q  <= 1'b0;
            error_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            cpu_ready_q <= 1'b0;
            // A clear is overridden below when an error completes on this edge
            if (bus_error_clr) begin
                bus_error_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        addr_q  <= cpu_la_addr;
                        idx_q   <= w_sel - C_SEL_ONE;
                        first_q <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= w_mapped ? ST_BUSY : ST_ERR;
                    end
                end
                ST_BUSY: begin
                    first_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    cnt_q   <= cnt_q + 1'b1;
`endif
                    // Fixed slaves present data one cycle after the request
                    if (w_fixed_sel ? !first_q : w_ack_sel) begin
                        cpu_rdata_q <= w_rdata_sel;
                        cpu_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        cpu_rdata_q  <= ERROR_DATA;
                        cpu_ready_q  <= 1'b1;
                        bus_error_q  <= 1'b1;
                        error_addr_q <= addr_q;
                        state_q      <= ST_DONE;
                    end
`endif
                end
                ST_ERR: begin
                    cpu_rdata_q  <= ERROR_DATA;
                    cpu_ready_q  <= 1'b1;
                    bus_error_q  <= 1'b1;
                    error_addr_q <= addr_q;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    // Gap cycle lets the CPU drop or replace mem_valid
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign bus_error  = bus_error_q;
    assign error_addr = error_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_bus_decoder
// Description : Self-checking bench for picorv32_bus_decoder (default build,
//               BUS_TIMEOUT_EN undefined). Expected behaviour comes from a
//               latency/decode table per access and a sticky-error model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_bus_decoder;

    localparam int N = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_valid;
    logic [31:0]       cpu_la_addr;
    logic [3:0]        cpu_wstrb;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [N-1:0]      slave_req;
    logic [N-1:0]      slave_ack;
    logic [N*32-1:0]   slave_rdata;
    logic              bus_error_clr;
    logic              bus_error;
    logic [31:0]       error_addr;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic              exp_err;
    logic [31:0]       exp_eaddr;

    picorv32_bus_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_valid     (cpu_valid),
        .cpu_la_addr   (cpu_la_addr),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .slave_req     (slave_req),
        .slave_ack     (slave_ack),
        .slave_rdata   (slave_rdata),
        .bus_error_clr (bus_error_clr),
        .bus_error     (bus_error),
        .error_addr    (error_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access starting in IDLE; ends back in IDLE.
    // d = BUSY cycle (1-based) in which an ack slave raises its ack.
    task automatic access(input logic [31:0] addr, input logic [3:0] ws, input int d,
                          input bit clr_on_done, input bit use_fw, input logic [31:0] fw);
        logic [3:0]   sel;
        bit           mapped;
        bit           fixed;
        int           idx;
        int           lat;
        logic [N-1:0] exp_req;
        logic [31:0]  exp_rd;
        sel    = addr[31:28];
        mapped = (sel >= 1) && (sel <= N);
        idx    = mapped ? int'(sel) - 1 : 0;
        fixed  = mapped && (idx < 3);
        lat    = !mapped ? 1 : (fixed ? 2 : d);
        exp_req = mapped ? (N'(1) << idx) : '0;
        for (int k = 0; k < N; k++) slave_rdata[32*k +: 32] = $urandom();
        if (use_fw) slave_rdata[32*idx +: 32] = fw;
        exp_rd = mapped ? slave_rdata[32*idx +: 32] : 32'hDEAD_BEEF;

        cpu_valid   = 1'b1;
        cpu_la_addr = addr;
        cpu_wstrb   = ws;
        tick();
        // Routing must depend only on what was sampled at E0
        cpu_valid   = 1'b0;
        cpu_la_addr = $urandom();
        cpu_wstrb   = 4'($urandom());
        for (int c = 1; c <= lat; c++) begin
            chk("req_busy", 32'(slave_req), 32'(exp_req));
            chk("ready_early", 32'(cpu_ready), 32'h0);
            slave_ack      = N'($urandom());
            slave_ack[idx] = mapped && !fixed && (c == lat);
            if (c == lat && clr_on_done) bus_error_clr = 1'b1;
            tick();
            bus_error_clr = 1'b0;
        end
        slave_ack = '0;
        if (!mapped) begin
            exp_err   = 1'b1;
            exp_eaddr = addr;
        end else if (clr_on_done) begin
            exp_err = 1'b0;
        end
        chk("ready_pulse", 32'(cpu_ready), 32'h1);
        chk("rdata", cpu_rdata, exp_rd);
        chk("req_dropped", 32'(slave_req), 32'h0);
        chk("bus_error", 32'(bus_error), 32'(exp_err));
        chk("error_addr", error_addr, exp_eaddr);
        tick();
        chk("ready_width", 32'(cpu_ready), 32'h0);
        chk("rdata_hold", cpu_rdata, exp_rd);
        chk("req_done", 32'(slave_req), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_ready;
        int bad_req;
        reset         = 1'b1;
        cpu_valid     = 1'b0;
        cpu_la_addr   = '0;
        cpu_wstrb     = '0;
        slave_ack     = '0;
        slave_rdata   = '0;
        bus_error_clr = 1'b0;
        exp_err       = 1'b0;
        exp_eaddr     = '0;
        tick();
        tick();
        chk("rst_ready", 32'(cpu_ready), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_req", 32'(slave_req), 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
        chk("rst_error_addr", error_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Fixed slave 0 read
        access(32'h1000_0004, 4'h0, 0, 1'b0, 1'b1, 32'h1234_5678);
        chk("fixed_rdata_const", cpu_rdata, 32'h1234_5678);
        // Ack slave 3 write, ack after 5 cycles
        access(32'h4000_0000, 4'h1, 5, 1'b0, 1'b0, 32'h0);
        chk("ack_no_error", 32'(bus_error), 32'h0);
        // Unmapped: selector 0 and selector above SLAVES
        access(32'h0000_0010, 4'h0, 0, 1'b0, 1'b0, 32'h0);
        access(32'hF000_0000, 4'hF, 0, 1'b0, 1'b0, 32'h0);
        chk("err_addr_last", error_addr, 32'hF000_0000);
        // Clear coinciding with a new error: error wins
        access(32'h9000_0020, 4'h0, 0, 1'b1, 1'b0, 32'h0);
        chk("clr_vs_err", 32'(bus_error), 32'h1);
        // Lone clear
        bus_error_clr = 1'b1;
        tick();
        bus_error_clr = 1'b0;
        exp_err = 1'b0;
        chk("lone_clear", 32'(bus_error), 32'h0);

        // Randomized accesses
        for (int t = 0; t < 30; t++) begin
            access({4'($urandom_range(0, 15)), 28'($urandom())}, 4'($urandom()),
                   int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), 1'b0, 32'h0);
        end

        // Ack slave 4 never acks: without the watchdog the access never completes
        cpu_valid   = 1'b1;
        cpu_la_addr = 32'h5000_0000;
        cpu_wstrb   = 4'h0;
        tick();
        cpu_valid  = 1'b0;
        seen_ready = 0;
        bad_req    = 0;
        for (int c = 0; c < 1000; c++) begin
            if (cpu_ready !== 1'b0) seen_ready++;
            if (slave_req !== 8'h10) bad_req++;
            tick();
        end
        chk("hang_no_ready", 32'(seen_ready), 32'h0);
        chk("hang_req_held", 32'(bad_req), 32'h0);

        // Make sure the error flag is set so reset clearing it is observable
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_err   = 1'b0;
        exp_eaddr = '0;
        access(32'hC000_0000, 4'h0, 0, 1'b0, 1'b0, 32'h0);
        chk("pre_reset_err", 32'(bus_error), 32'h1);

        // Reset in BUSY cycle 2 of an ack slave
        cpu_valid   = 1'b1;
        cpu_la_addr = 32'h4000_0000;
        tick();
        cpu_valid = 1'b0;
        chk("busy_c1_req", 32'(slave_req), 32'h08);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_req", 32'(slave_req), 32'h0);
        chk("rst_mid_ready", 32'(cpu_ready), 32'h0);
        chk("rst_mid_err", 32'(bus_error), 32'h0);
        slave_ack  = 8'h08;
        seen_ready = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ready !== 1'b0) seen_ready++;
        end
        slave_ack = '0;
        chk("late_ack_ignored", 32'(seen_ready), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
